// File: rtl/iob_piso_reg.sv
//------------------------------------------------------------------------------
// Module   : iob_piso_reg
// Brief    : Parallel-load shift register; mirror of iob_sipo_reg.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module iob_piso_reg #(
   parameter int unsigned DATA_W    = 21,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic              clk_i,
   input  logic              cke_i,
   input  logic              arst_i,
   input  logic              load_i,
   input  logic              shift_i,
   input  logic [DATA_W-1:0] p_i,
   output logic              s_o
);

   logic [DATA_W-1:0] sreg_d;
   logic [DATA_W-1:0] sreg_q;
   logic [DATA_W-1:0] sreg_shifted;

   // Shift toward the output end, zero-filling the far end.
   if (MSB_FIRST) begin : g_msb_first
      assign sreg_shifted = {sreg_q[DATA_W-2:0], 1'b0};
      assign s_o          = sreg_q[DATA_W-1];
   end else begin : g_lsb_first
      assign sreg_shifted = {1'b0, sreg_q[DATA_W-1:1]};
      assign s_o          = sreg_q[0];
   end

   always_comb begin
      sreg_d = sreg_q;
      if (load_i) begin
         sreg_d = p_i;
      end else if (shift_i) begin
         sreg_d = sreg_shifted;
      end
   end

   iob_reg_ca #(
      .DATA_W (DATA_W),
      .RST_VAL({DATA_W{1'b0}})
   ) u_sreg (
      .clk_i (clk_i),
      .cke_i (cke_i),
      .arst_i(arst_i),
      .d_i   (sreg_d),
      .q_o   (sreg_q)
   );

endmodule

`default_nettype wire

// File: rtl/iob_reg_ca.sv
//------------------------------------------------------------------------------
// Module   : iob_reg_ca
// Brief    : Register with clock enable and asynchronous active-high reset.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module iob_reg_ca #(
   parameter int unsigned       DATA_W  = 1,
   parameter logic [DATA_W-1:0] RST_VAL = '0
) (
   input  logic              clk_i,
   input  logic              cke_i,
   input  logic              arst_i,
   input  logic [DATA_W-1:0] d_i,
   output logic [DATA_W-1:0] q_o
);

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         q_o <= RST_VAL;
      end else if (cke_i) begin
         q_o <= d_i;
      end
   end

endmodule

`default_nettype wire

// File: rtl/iob_piso_serializer.sv
//------------------------------------------------------------------------------
// Module   : iob_piso_serializer
// Brief    : Valid/ready parallel-in serial-out serializer, gapless back-to-back.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module iob_piso_serializer #(
   parameter int unsigned DATA_W    = 21,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic              clk_i,
   input  logic              cke_i,
   input  logic              arst_n_i,
   input  logic              p_valid_i,
   input  logic [DATA_W-1:0] p_data_i,
   output logic              p_ready_o,
   output logic              s_o,
   output logic              s_valid_o,
   input  logic              s_ready_i,
   output logic              s_last_o,
   output logic              busy_o
);

   localparam int unsigned      CNT_W   = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t           state_d;
   state_t           state_q;
   logic             state_q_raw;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_q;
   logic             arst;
   logic             in_shift;
   logic             cnt_zero;
   logic             beat;
   logic             load;
   logic             shift;

   assign arst     = ~arst_n_i;
   assign state_q  = state_t'(state_q_raw);
   assign in_shift = (state_q == ST_SHIFT);
   assign cnt_zero = (cnt_q == '0);
   assign beat     = in_shift & s_ready_i & cke_i;

   // Ready opens on the last beat so the next word reloads without a gap.
   assign p_ready_o = cke_i & (~in_shift | (s_ready_i & cnt_zero));
   assign load      = p_valid_i & p_ready_o;
   assign shift     = beat & ~cnt_zero;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (load) begin
         state_d = ST_SHIFT;
         cnt_d   = CNT_MAX;
      end else if (beat) begin
         if (cnt_zero) begin
            state_d = ST_IDLE;
         end else begin
            cnt_d = cnt_q - CNT_ONE;
         end
      end
   end

   iob_reg_ca #(
      .DATA_W (1),
      .RST_VAL(1'b0)
   ) u_state_reg (
      .clk_i (clk_i),
      .cke_i (cke_i),
      .arst_i(arst),
      .d_i   (state_d),
      .q_o   (state_q_raw)
   );

   iob_reg_ca #(
      .DATA_W (CNT_W),
      .RST_VAL({CNT_W{1'b0}})
   ) u_cnt_reg (
      .clk_i (clk_i),
      .cke_i (cke_i),
      .arst_i(arst),
      .d_i   (cnt_d),
      .q_o   (cnt_q)
   );

   iob_piso_reg #(
      .DATA_W   (DATA_W),
      .MSB_FIRST(MSB_FIRST)
   ) u_piso (
      .clk_i  (clk_i),
      .cke_i  (cke_i),
      .arst_i (arst),
      .load_i (load),
      .shift_i(shift),
      .p_i    (p_data_i),
      .s_o    (s_o)
   );

   assign s_valid_o = in_shift;
   assign busy_o    = in_shift;
   assign s_last_o  = in_shift & cnt_zero;

endmodule

`default_nettype wire
